// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the classifier layer sequencers: FSM state encoding and
// width helpers reused by every layer instance.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    CLR   = 3'd2,
    ACC   = 3'd3,
    BIAS  = 3'd4,
    DRAIN = 3'd5,
    CMP   = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Address width for 'value' distinct entries, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Control sequencer for one fully-connected layer: per output neuron it loads the
// serialiser, streams N_IN weights into the MAC, adds the bias, drains and strobes compare.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int N_IN      = 10,
  parameter int N_OUT     = 10,
  parameter int MAC_LAT   = 2,
  parameter int START_DLY = 6,
  localparam int W_AW     = clog2_min1(N_IN * N_OUT),
  localparam int B_AW     = clog2_min1(N_OUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            pts_load,
  output logic            pts_out,
  output logic            weight_rd,
  output logic [W_AW-1:0] weight_addr,
  output logic            bias_rd,
  output logic [B_AW-1:0] bias_addr,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            compare_en,
  output logic [B_AW-1:0] neuron_idx,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state
);

  // One shared cycle counter serves WAIT, ACC and DRAIN.
  localparam int CNT_MAX = max3(START_DLY, N_IN, MAC_LAT);
  localparam int CNT_W   = clog2_min1(CNT_MAX);

  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((START_DLY > 0) ? START_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] ACC_LAST   = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam logic [B_AW-1:0]  J_LAST     = B_AW'(N_OUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              start_q;
  logic [CNT_W-1:0]  cnt;
  logic [B_AW-1:0]   j;
  logic [W_AW-1:0]   waddr;
  logic              start_evt;
  logic              counting;

  assign start_evt = (state == IDLE) && start && !start_q;
  assign counting  = (state == WAIT) || (state == ACC) || (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_evt) state_nxt = (START_DLY == 0) ? CLR : WAIT;
      WAIT:  if (cnt == WAIT_LAST) state_nxt = CLR;
      CLR:   state_nxt = ACC;
      ACC:   if (cnt == ACC_LAST) state_nxt = BIAS;
      BIAS:  state_nxt = (MAC_LAT == 0) ? CMP : DRAIN;
      DRAIN: if (cnt == DRAIN_LAST) state_nxt = CMP;
      CMP:   state_nxt = (j == J_LAST) ? DONE : CLR;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // The weight address is advanced only between reads, so it always shows the
  // address currently being read and stops at N_IN*N_OUT-1 without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      cnt     <= '0;
      j       <= '0;
      waddr   <= '0;
    end else begin
      start_q <= start;
      if (abort) begin
        cnt   <= '0;
        j     <= '0;
        waddr <= '0;
      end else begin
        if (counting && (state_nxt == state)) cnt <= cnt + 1'b1;
        else                                  cnt <= '0;

        if (start_evt)                                j <= '0;
        else if ((state == CMP) && (state_nxt == CLR)) j <= j + 1'b1;

        if (start_evt)                                 waddr <= '0;
        else if ((state == ACC) && (cnt != ACC_LAST))  waddr <= waddr + 1'b1;
        else if ((state == CLR) && (j != '0))          waddr <= waddr + 1'b1;
      end
    end
  end

  assign pts_load    = (state == CLR);
  assign mac_clr     = (state == CLR);
  assign pts_out     = (state == ACC);
  assign weight_rd   = (state == ACC);
  assign bias_rd     = (state == BIAS);
  assign mac_en      = (state == CLR) || (state == ACC) || (state == BIAS);
  assign compare_en  = (state == CMP);
  assign done        = (state == DONE);
  assign busy        = (state != IDLE);
  assign weight_addr = waddr;
  assign bias_addr   = j;
  assign neuron_idx  = j;
  assign dbg_state   = state;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: three parameterisations, strobe events checked against
// an expected-event queue filled by a cycle model of the sequencing.
module tb_layer_sequencer;
  import nn_ctrl_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  abort;
  logic [15:0] cyc = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  // dut0: N_IN=4 N_OUT=3 MAC_LAT=2 START_DLY=2
  logic       pts_load0, pts_out0, weight_rd0, bias_rd0, mac_en0, mac_clr0;
  logic       compare_en0, busy0, done0;
  logic [3:0] weight_addr0;
  logic [1:0] bias_addr0, neuron_idx0;
  logic [2:0] dbg_state0;
  // dut1: MAC_LAT=0 START_DLY=0
  logic       pts_load1, pts_out1, weight_rd1, bias_rd1, mac_en1, mac_clr1;
  logic       compare_en1, busy1, done1;
  logic [3:0] weight_addr1;
  logic [1:0] bias_addr1, neuron_idx1;
  logic [2:0] dbg_state1;
  // dut2: N_IN=1 N_OUT=1
  logic       pts_load2, pts_out2, weight_rd2, bias_rd2, mac_en2, mac_clr2;
  logic       compare_en2, busy2, done2;
  logic [0:0] weight_addr2;
  logic [0:0] bias_addr2, neuron_idx2;
  logic [2:0] dbg_state2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  layer_sequencer #(.N_IN(4), .N_OUT(3), .MAC_LAT(2), .START_DLY(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .pts_load(pts_load0), .pts_out(pts_out0), .weight_rd(weight_rd0), .weight_addr(weight_addr0),
    .bias_rd(bias_rd0), .bias_addr(bias_addr0), .mac_en(mac_en0), .mac_clr(mac_clr0),
    .compare_en(compare_en0), .neuron_idx(neuron_idx0), .busy(busy0), .done(done0),
    .dbg_state(dbg_state0));

  layer_sequencer #(.N_IN(4), .N_OUT(3), .MAC_LAT(0), .START_DLY(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .pts_load(pts_load1), .pts_out(pts_out1), .weight_rd(weight_rd1), .weight_addr(weight_addr1),
    .bias_rd(bias_rd1), .bias_addr(bias_addr1), .mac_en(mac_en1), .mac_clr(mac_clr1),
    .compare_en(compare_en1), .neuron_idx(neuron_idx1), .busy(busy1), .done(done1),
    .dbg_state(dbg_state1));

  layer_sequencer #(.N_IN(1), .N_OUT(1), .MAC_LAT(2), .START_DLY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .pts_load(pts_load2), .pts_out(pts_out2), .weight_rd(weight_rd2), .weight_addr(weight_addr2),
    .bias_rd(bias_rd2), .bias_addr(bias_addr2), .mac_en(mac_en2), .mac_clr(mac_clr2),
    .compare_en(compare_en2), .neuron_idx(neuron_idx2), .busy(busy2), .done(done2),
    .dbg_state(dbg_state2));

  // Strobe byte: pts_load pts_out weight_rd bias_rd mac_en mac_clr compare_en done
  localparam logic [7:0] EV_CLR  = 8'b1000_1100;
  localparam logic [7:0] EV_ACC  = 8'b0110_1000;
  localparam logic [7:0] EV_BIAS = 8'b0001_1000;
  localparam logic [7:0] EV_CMP  = 8'b0000_0010;
  localparam logic [7:0] EV_DONE = 8'b0000_0001;

  task automatic push_ev(input int id, input int c, input logic [7:0] s, input int v);
    logic [W-1:0] e;
    e = {16'(c), s, 8'(v)};
    case (id)
      0: exp_q.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // Cycle n of a run is the period n clocks after the period in which start rose (t0).
  task automatic push_run(input int id, input int t0, input int n_in, input int n_out,
                          input int lat, input int dly, input int lim);
    int base;
    for (int jj = 0; jj < n_out; jj++) begin
      base = t0 + dly + 1 + jj * (n_in + lat + 3);
      if (base <= lim) push_ev(id, base, EV_CLR, 0);
      for (int ii = 0; ii < n_in; ii++)
        if (base + 1 + ii <= lim) push_ev(id, base + 1 + ii, EV_ACC, jj * n_in + ii);
      if (base + 1 + n_in <= lim) push_ev(id, base + 1 + n_in, EV_BIAS, jj);
      if (base + 2 + n_in + lat <= lim) push_ev(id, base + 2 + n_in + lat, EV_CMP, jj);
    end
    base = t0 + dly + n_out * (n_in + lat + 3) + 1;
    if (base <= lim) push_ev(id, base, EV_DONE, 0);
  endtask

  task automatic check_ev(input int id, input logic [W-1:0] obs);
    logic [W-1:0] e;
    logic         got;
    got = 1'b0;
    e   = '0;
    case (id)
      0: if (exp_q.size() > 0) begin e = exp_q.pop_front(); got = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); got = 1'b1; end
    endcase
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got cyc=%0d strobes=%b val=%0d, required no event",
               id, obs[31:16], obs[15:8], obs[7:0]);
    end else if (obs !== e) begin
      n_fail++;
      $display("FAIL event dut%0d: got cyc=%0d strobes=%b val=%0d, required cyc=%0d strobes=%b val=%0d",
               id, obs[31:16], obs[15:8], obs[7:0], e[31:16], e[15:8], e[7:0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return exp_q.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic wait_empty(input int id, input int budget);
    int k;
    k = 0;
    while (qsize(id) > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (qsize(id) > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout dut%0d: %0d events outstanding, required 0", id, qsize(id));
    end
  endtask

  task automatic start_run(input int id, output int t0);
    @(negedge clk);
    start[id] = 1'b1;
    t0 = int'(cyc);
  endtask

  function automatic int outs0();
    return int'({pts_load0, pts_out0, weight_rd0, weight_addr0, bias_rd0, bias_addr0, mac_en0,
                 mac_clr0, compare_en0, neuron_idx0, busy0, done0});
  endfunction

  // Monitor: any asserted strobe is an event to be matched against the queue.
  logic [7:0] s0, s1, s2;
  logic [7:0] v0, v1, v2;
  always @(negedge clk) begin
    if (rst_n) begin
      s0 = {pts_load0, pts_out0, weight_rd0, bias_rd0, mac_en0, mac_clr0, compare_en0, done0};
      v0 = weight_rd0 ? 8'(weight_addr0) : bias_rd0 ? 8'(bias_addr0) :
           compare_en0 ? 8'(neuron_idx0) : 8'd0;
      if (s0 != 8'd0) check_ev(0, {cyc, s0, v0});
      s1 = {pts_load1, pts_out1, weight_rd1, bias_rd1, mac_en1, mac_clr1, compare_en1, done1};
      v1 = weight_rd1 ? 8'(weight_addr1) : bias_rd1 ? 8'(bias_addr1) :
           compare_en1 ? 8'(neuron_idx1) : 8'd0;
      if (s1 != 8'd0) check_ev(1, {cyc, s1, v1});
      s2 = {pts_load2, pts_out2, weight_rd2, bias_rd2, mac_en2, mac_clr2, compare_en2, done2};
      v2 = weight_rd2 ? 8'(weight_addr2) : bias_rd2 ? 8'(bias_addr2) :
           compare_en2 ? 8'(neuron_idx2) : 8'd0;
      if (s2 != 8'd0) check_ev(2, {cyc, s2, v2});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    repeat (3) @(negedge clk);
    check_val("reset_outs0", outs0(), 0);
    check_val("reset_busy1", int'(busy1), 0);
    check_val("reset_busy2", int'(busy2), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_outs0", outs0(), 0);

    // Full run, start then held high.
    start_run(0, t0);
    push_run(0, t0, 4, 3, 2, 2, 1000);
    @(negedge clk);
    check_val("run1_busy_c1", int'(busy0), 1);
    check_val("run1_state_c1", int'(dbg_state0), int'(WAIT));
    wait_empty(0, 60);
    @(negedge clk);
    check_val("run1_busy_after", int'(busy0), 0);
    check_val("run1_last_waddr", int'(weight_addr0), 11);

    // Held start must not retrigger; a fresh edge gives an identical run.
    repeat (40) @(negedge clk);
    check_val("held_start_idle", int'(busy0), 0);
    start[0] = 1'b0;
    @(negedge clk);
    start_run(0, t0);
    push_run(0, t0, 4, 3, 2, 2, 1000);
    wait_empty(0, 60);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during neuron 1 ACC.
    start_run(0, t0);
    push_run(0, t0, 4, 3, 2, 2, t0 + 15);
    while (int'(cyc) != t0 + 15) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check_val("abort_outs0", outs0(), 0);
    check_val("abort_state", int'(dbg_state0), int'(IDLE));
    check_val("abort_q_drained", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    check_val("abort_no_done", int'(busy0), 0);
    start[0] = 1'b0;
    @(negedge clk);
    start_run(0, t0);
    push_run(0, t0, 4, 3, 2, 2, 1000);
    wait_empty(0, 60);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Abort and start edge together: abort wins, held start stays ignored.
    @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort_beats_start", int'(busy0), 0);
    start[0] = 1'b0;
    @(negedge clk);

    // Asynchronous reset in DRAIN.
    start_run(0, t0);
    push_run(0, t0, 4, 3, 2, 2, t0 + 8);
    @(negedge clk);
    start[0] = 1'b0;
    while (int'(cyc) != t0 + 9) @(negedge clk);
    check_val("pre_reset_state", int'(dbg_state0), int'(DRAIN));
    #2 rst_n = 1'b0;
    #1 check_val("async_reset_outs0", outs0(), 0);
    check_val("reset_q_drained", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("post_reset_idle", int'(dbg_state0), int'(IDLE));

    // MAC_LAT=0, START_DLY=0 instance.
    start_run(1, t0);
    push_run(1, t0, 4, 3, 0, 0, 1000);
    wait_empty(1, 40);
    start[1] = 1'b0;
    @(negedge clk);
    check_val("dut1_idle_after", int'(busy1), 0);

    // Single-input single-neuron instance.
    start_run(2, t0);
    push_run(2, t0, 1, 1, 2, 2, 1000);
    wait_empty(2, 20);
    start[2] = 1'b0;
    @(negedge clk);
    check_val("dut2_idle_after", int'(busy2), 0);

    repeat (5) @(negedge clk);
    check_val("final_q0", exp_q.size(), 0);
    check_val("final_q1", exp_q1.size(), 0);
    check_val("final_q2", exp_q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
